// File: rtl/uart_tx.sv
// Buffered UART transmitter: FIFO-fed frame FSM, LSB-first with optional parity and 1-2 stop bits.
// A word pushed into an empty FIFO starts its start bit one cycle later; ready drops while the FIFO is full.
module uart_tx #(
  parameter int CLK        = 50000000,
  parameter int BAUD_RATE  = 115200,
  parameter int BITS       = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [BITS-1:0]               data,
  input  logic                          valid,
  output logic                          ready,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CLK_DIVISOR = CLK / BAUD_RATE;
  localparam int BAUD_W      = $clog2(CLK_DIVISOR) + 1;
  localparam int BIT_W       = $clog2(BITS) + 1;
  localparam int PTR_W       = $clog2(FIFO_DEPTH);
  localparam int LVL_W       = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [BITS-1:0]  mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [BITS-1:0]  head;

  state_t           state_q, state_nxt;
  logic [BAUD_W-1:0] baud_q, baud_nxt;
  logic [BIT_W-1:0] bit_q, bit_nxt;
  logic [BITS-1:0]  shift_q, shift_nxt;
  logic             par_q, par_nxt;
  logic             tx_q, tx_nxt;
  logic             baud_last;

  assign ready      = (level != LVL_W'(FIFO_DEPTH));
  assign push       = valid && ready;
  assign fifo_empty = (level == '0);
  assign head       = mem[rd_ptr];
  assign fifo_level = level;
  assign tx         = tx_q;
  assign busy       = (state_q != S_IDLE) || (level != '0);
  assign baud_last  = (baud_q == BAUD_W'(CLK_DIVISOR - 1));

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_nxt;
      baud_q  <= baud_nxt;
      bit_q   <= bit_nxt;
      shift_q <= shift_nxt;
      par_q   <= par_nxt;
      tx_q    <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    baud_nxt  = baud_q + 1'b1;
    bit_nxt   = bit_q;
    shift_nxt = shift_q;
    par_nxt   = par_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_nxt = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = S_START;
          shift_nxt = head;
          par_nxt   = (PARITY == 2) ? ^head : ~^head;
        end
      end
      S_START: begin
        if (baud_last) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (baud_last) begin
          baud_nxt  = '0;
          shift_nxt = shift_q >> 1;
          if (bit_q == BIT_W'(BITS - 1)) begin
            bit_nxt   = '0;
            state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_nxt = bit_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (baud_last) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        // bit_q counts stop bits here; the final one chains straight into the next frame
        if (baud_last) begin
          baud_nxt = '0;
          if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            bit_nxt = '0;
            if (!fifo_empty) begin
              pop       = 1'b1;
              state_nxt = S_START;
              shift_nxt = head;
              par_nxt   = (PARITY == 2) ? ^head : ~^head;
            end else begin
              state_nxt = S_IDLE;
            end
          end else begin
            bit_nxt = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        baud_nxt  = '0;
        bit_nxt   = '0;
      end
    endcase
  end

  // tx is registered from the next state so each bit lands exactly on its boundary edge.
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      S_IDLE:   tx_nxt = 1'b1;
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = shift_nxt[0];
      S_PARITY: tx_nxt = par_nxt;
      S_STOP:   tx_nxt = 1'b1;
      default:  tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances (no parity, even, odd, two stop bits) at 10 clocks per bit.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] din [4];
  logic [3:0] vld;
  logic [3:0] rdy;
  logic [3:0] txv;
  logic [3:0] bsy;
  logic [2:0] l0, l1, l2, l3;

  int tests = 0;
  int fails = 0;

  logic       txlog  [0:1023];
  logic       bsylog [0:1023];
  logic       rdylog [0:1023];
  logic [2:0] lvllog [0:1023];
  int         acc    [0:7];
  logic [7:0] wq [$];

  always #5 clk = ~clk;

  uart_tx #(.CLK(1152000), .BAUD_RATE(115200), .BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_none (
    .clk(clk), .reset_n(reset_n), .data(din[0]), .valid(vld[0]), .ready(rdy[0]),
    .tx(txv[0]), .busy(bsy[0]), .fifo_level(l0));
  uart_tx #(.CLK(1152000), .BAUD_RATE(115200), .BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_even (
    .clk(clk), .reset_n(reset_n), .data(din[1]), .valid(vld[1]), .ready(rdy[1]),
    .tx(txv[1]), .busy(bsy[1]), .fifo_level(l1));
  uart_tx #(.CLK(1152000), .BAUD_RATE(115200), .BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_odd (
    .clk(clk), .reset_n(reset_n), .data(din[2]), .valid(vld[2]), .ready(rdy[2]),
    .tx(txv[2]), .busy(bsy[2]), .fifo_level(l2));
  uart_tx #(.CLK(1152000), .BAUD_RATE(115200), .BITS(8), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_stop2 (
    .clk(clk), .reset_n(reset_n), .data(din[3]), .valid(vld[3]), .ready(rdy[3]),
    .tx(txv[3]), .busy(bsy[3]), .fifo_level(l3));

  function automatic logic [2:0] lvl_of(input logic [1:0] s);
    case (s)
      2'd0:    return l0;
      2'd1:    return l1;
      2'd2:    return l2;
      default: return l3;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge. Holds valid until every queued word is accepted and logs
  // the outputs at the negedge after each of ncyc posedges (cycle c = after posedge c).
  task automatic run(input logic [1:0] s, input int ncyc);
    int   wi;
    logic will;
    wi = 0;
    for (int i = 0; i < 8; i++) acc[i] = -1;
    din[s] = wq[0];
    vld[s] = 1'b1;
    txlog[0] = txv[s];
    will = vld[s] && rdy[s];
    for (int c = 1; c <= ncyc; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (will) begin
        acc[wi] = c;
        wi++;
        if (wi >= wq.size()) vld[s] = 1'b0;
        else din[s] = wq[wi];
      end
      txlog[c]  = txv[s];
      bsylog[c] = bsy[s];
      rdylog[c] = rdy[s];
      lvllog[c] = lvl_of(s);
      will = vld[s] && rdy[s];
    end
  endtask

  // bits[i] is the i-th transmitted bit; each must hold for 10 logged cycles.
  task automatic check_frame(input string tag, input int start, input logic [15:0] bits, input int n);
    int err;
    err = 0;
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 10; k++)
        if (txlog[start + i*10 + k] !== bits[i]) err++;
    check(tag, err, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    vld     = 4'h0;
    for (int i = 0; i < 4; i++) din[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx",    txv, 4'hF);
    check("rst_ready", rdy, 4'hF);
    check("rst_busy",  bsy, 4'h0);
    check("rst_level", l0, 0);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_tx",   txv, 4'hF);
    check("idle_busy", bsy, 4'h0);

    // Single 0xA5 frame, no parity
    wq = '{8'hA5};
    run(2'd0, 110);
    check("a5_accept",   acc[0], 1);
    check("a5_pre_idle", txlog[1], 1'b1);
    check_frame("a5_frame", 2, {1'b1, 8'hA5, 1'b0}, 10);
    check("a5_busy_last", bsylog[101], 1'b1);
    check("a5_busy_fall", bsylog[102], 1'b0);
    check("a5_tx_idle",   txlog[102], 1'b1);

    // Six words with valid held: fill, full stall, back-to-back frames
    wq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run(2'd0, 610);
    for (int i = 0; i < 5; i++) check($sformatf("b2b_accept%0d", i + 1), acc[i], i + 1);
    check("b2b_pushpop_lvl", lvllog[2], 1);
    check("b2b_ready_hi",    rdylog[4], 1'b1);
    check("b2b_full_ready",  rdylog[5], 1'b0);
    check("b2b_full_level",  lvllog[5], 4);
    check("b2b_pop_lvl",     lvllog[102], 3);
    check("b2b_accept6",     acc[5], 103);
    check("b2b_refill_lvl",  lvllog[103], 4);
    check_frame("b2b_f1", 2,   {1'b1, 8'h01, 1'b0}, 10);
    check_frame("b2b_f2", 102, {1'b1, 8'h02, 1'b0}, 10);
    check_frame("b2b_f3", 202, {1'b1, 8'h03, 1'b0}, 10);
    check_frame("b2b_f4", 302, {1'b1, 8'h04, 1'b0}, 10);
    check_frame("b2b_f5", 402, {1'b1, 8'h05, 1'b0}, 10);
    check_frame("b2b_f6", 502, {1'b1, 8'h06, 1'b0}, 10);
    check("b2b_busy_last", bsylog[601], 1'b1);
    check("b2b_busy_fall", bsylog[602], 1'b0);

    // Parity: 0x07 has three ones -> even bit 1, odd bit 0
    wq = '{8'h07};
    run(2'd1, 120);
    check_frame("even_frame", 2, {1'b1, 1'b1, 8'h07, 1'b0}, 11);
    check("even_busy_last", bsylog[111], 1'b1);
    check("even_busy_fall", bsylog[112], 1'b0);
    wq = '{8'h07};
    run(2'd2, 120);
    check_frame("odd_frame", 2, {1'b1, 1'b0, 8'h07, 1'b0}, 11);

    // Two stop bits, back-to-back 0x00 then 0xFF
    wq = '{8'h00, 8'hFF};
    run(2'd3, 230);
    check_frame("stop2_f1", 2,   {2'b11, 8'h00, 1'b0}, 11);
    check_frame("stop2_f2", 112, {2'b11, 8'hFF, 1'b0}, 11);
    check("stop2_busy_fall", bsylog[222], 1'b0);

    // Reset during data bit 3 of 0x3C with a second word still queued
    wq = '{8'h3C, 8'h11};
    run(2'd0, 45);
    check("abort_bit0",  txlog[12], 1'b0);
    check("abort_bit2",  txlog[32], 1'b1);
    check("abort_lvl",   lvllog[45], 1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_tx",    txv[0], 1'b1);
    check("abort_level", l0, 0);
    check("abort_busy",  bsy[0], 1'b0);
    check("abort_ready", rdy[0], 1'b1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_quiet", bsy[0], 1'b0);
    wq = '{8'h5A};
    run(2'd0, 110);
    check_frame("after_rst_frame", 2, {1'b1, 8'h5A, 1'b0}, 10);
    check("after_rst_busy", bsylog[102], 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
